// File: rtl/avm_arbiter2.sv
// Two-master Avalon-MM arbiter: fair round-robin with a per-master hold limit,
// combinational forwarding of the granted master onto one slave port.
module avm_arbiter2 #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic        avm_clk,
  input  logic        avm_rst,
  input  logic [4:0]  m0_address,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [31:0] m0_writedata,
  output logic [31:0] m0_readdata,
  output logic        m0_waitrequest,
  input  logic [4:0]  m1_address,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [31:0] m1_writedata,
  output logic [31:0] m1_readdata,
  output logic        m1_waitrequest,
  output logic [4:0]  avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest
);

  localparam int unsigned HOLD_W = 4;
  localparam logic [HOLD_W-1:0] HOLD_MAX = 4'd15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              lw_q, lw_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

  logic req0, req1;
  logic hold_limit;
  logic [HOLD_W-1:0] hold_inc;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // Handover is due once this completion brings the run to MAX_HOLD.
  assign hold_limit = ({1'b0, hold_cnt_q} + 5'd1) >= 5'(MAX_HOLD);
  assign hold_inc   = (hold_cnt_q == HOLD_MAX) ? HOLD_MAX : hold_cnt_q + 4'd1;

  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      state_q    <= IDLE;
      lw_q       <= 1'b1;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      lw_q       <= lw_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lw_d       = lw_q;
    hold_cnt_d = hold_cnt_q;
    unique case (state_q)
      IDLE: begin
        hold_cnt_d = '0;
        if (req0 && req1) state_d = lw_q ? GRANT0 : GRANT1;
        else if (req0)    state_d = GRANT0;
        else if (req1)    state_d = GRANT1;
      end
      GRANT0: begin
        if (!req0) begin
          lw_d       = 1'b0;
          hold_cnt_d = '0;
          state_d    = req1 ? GRANT1 : IDLE;
        end else if (!avm_waitrequest) begin
          if (req1 && hold_limit) begin
            lw_d       = 1'b0;
            hold_cnt_d = '0;
            state_d    = GRANT1;
          end else begin
            hold_cnt_d = hold_inc;
          end
        end
      end
      GRANT1: begin
        if (!req1) begin
          lw_d       = 1'b1;
          hold_cnt_d = '0;
          state_d    = req0 ? GRANT0 : IDLE;
        end else if (!avm_waitrequest) begin
          if (req0 && hold_limit) begin
            lw_d       = 1'b1;
            hold_cnt_d = '0;
            state_d    = GRANT0;
          end else begin
            hold_cnt_d = hold_inc;
          end
        end
      end
      default: begin
        state_d    = IDLE;
        hold_cnt_d = '0;
      end
    endcase
  end

  // Slave-side mux; the ungranted master always sees a stall.
  always_comb begin
    avm_address    = '0;
    avm_read       = 1'b0;
    avm_write      = 1'b0;
    avm_writedata  = '0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    unique case (state_q)
      GRANT0: begin
        avm_address    = m0_address;
        avm_read       = m0_read;
        avm_write      = m0_write;
        avm_writedata  = m0_writedata;
        m0_waitrequest = avm_waitrequest;
      end
      GRANT1: begin
        avm_address    = m1_address;
        avm_read       = m1_read;
        avm_write      = m1_write;
        avm_writedata  = m1_writedata;
        m1_waitrequest = avm_waitrequest;
      end
      default: ;
    endcase
  end

  assign m0_readdata = avm_readdata;
  assign m1_readdata = avm_readdata;

endmodule

// File: tb/tb_avm_arbiter2.sv
// Directed bench for avm_arbiter2: MAX_HOLD=4 instance plus a MAX_HOLD=1 instance on shared stimulus.
module tb_avm_arbiter2;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  m0_address, m1_address;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  logic [31:0] a_m0_rd, a_m1_rd, b_m0_rd, b_m1_rd;
  logic        a_m0_wr, a_m1_wr, b_m0_wr, b_m1_wr;
  logic [4:0]  a_addr, b_addr;
  logic        a_read, a_write, b_read, b_write;
  logic [31:0] a_wdata, b_wdata;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  avm_arbiter2 #(.MAX_HOLD(4)) dut_a (
    .avm_clk(clk), .avm_rst(rst),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_readdata(a_m0_rd), .m0_waitrequest(a_m0_wr),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_readdata(a_m1_rd), .m1_waitrequest(a_m1_wr),
    .avm_address(a_addr), .avm_read(a_read), .avm_write(a_write),
    .avm_writedata(a_wdata), .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest)
  );

  avm_arbiter2 #(.MAX_HOLD(1)) dut_b (
    .avm_clk(clk), .avm_rst(rst),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_readdata(b_m0_rd), .m0_waitrequest(b_m0_wr),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_readdata(b_m1_rd), .m1_waitrequest(b_m1_wr),
    .avm_address(b_addr), .avm_read(b_read), .avm_write(b_write),
    .avm_writedata(b_wdata), .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    m0_address = 5'd0; m1_address = 5'd0;
    m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
    m0_writedata = '0; m1_writedata = '0;
    avm_readdata = 32'hDEAD_BEEF;
    avm_waitrequest = 1'b0;

    // Reset state
    #2;
    chk("rst_read", 32'(a_read), 32'd0);
    chk("rst_addr", 32'(a_addr), 32'd0);
    chk("rst_m0_wait", 32'(a_m0_wr), 32'd1);
    chk("rst_m1_wait", 32'(a_m1_wr), 32'd1);
    chk("rdata_m0", a_m0_rd, 32'hDEAD_BEEF);
    chk("rdata_m1", a_m1_rd, 32'hDEAD_BEEF);
    chk("rdata_b", b_m1_rd ^ b_m0_rd, 32'd0);
    tick(); tick();

    // Lone m0 read of STATUS: one idle cycle, then slave access
    rst = 1'b0; m0_read = 1'b1; m0_address = 5'd8;
    #1;
    chk("c1_read", 32'(a_read), 32'd0);
    chk("c1_m0_wait", 32'(a_m0_wr), 32'd1);
    chk("c1_m1_wait", 32'(a_m1_wr), 32'd1);
    tick();
    chk("c2_read", 32'(a_read), 32'd1);
    chk("c2_addr", 32'(a_addr), 32'd8);
    chk("c2_m0_wait", 32'(a_m0_wr), 32'd0);
    chk("c2_m1_wait", 32'(a_m1_wr), 32'd1);
    tick();
    m0_read = 1'b0;
    #1;
    chk("rel_read", 32'(a_read), 32'd0);
    tick();
    chk("rel_idle_wait", 32'(a_m0_wr), 32'd1);

    // Async reset pulse, then both masters read continuously
    rst = 1'b1;
    #1;
    chk("rst2_read", 32'(a_read), 32'd0);
    tick();
    rst = 1'b0;
    m0_read = 1'b1; m0_address = 5'd0;
    m1_read = 1'b1; m1_address = 5'd4;
    #1;
    chk("both_idle_read", 32'(a_read), 32'd0);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("h4_m0_wait_%0d", i), 32'(a_m0_wr), 32'(((i / 4) % 2) == 1));
      chk($sformatf("h4_addr_%0d", i), 32'(a_addr), ((i / 4) % 2 == 1) ? 32'd4 : 32'd0);
      chk($sformatf("h4_read_%0d", i), 32'(a_read), 32'd1);
      chk($sformatf("h1_m1_wait_%0d", i), 32'(b_m1_wr), 32'((i % 2) == 0));
      chk($sformatf("h1_addr_%0d", i), 32'(b_addr), (i % 2 == 1) ? 32'd4 : 32'd0);
      chk($sformatf("h1_wr_%0d", i), {b_wdata[30:0], b_write}, 32'd0);
      chk($sformatf("h1_rd_%0d", i), 32'(b_read), 32'd1);
    end

    // dut_a now in GRANT1: m1 write stalled five cycles while m0 waits
    tick();
    m1_read = 1'b0; m1_write = 1'b1; m1_writedata = 32'h41;
    avm_waitrequest = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) tick();
      #1;
      chk($sformatf("stall_wdata_%0d", k), a_wdata, 32'h41);
      chk($sformatf("stall_write_%0d", k), 32'(a_write), 32'd1);
      chk($sformatf("stall_m1_wait_%0d", k), 32'(a_m1_wr), 32'd1);
      chk($sformatf("stall_m0_wait_%0d", k), 32'(a_m0_wr), 32'd1);
    end
    // Stall counts as one completion: three more before handover
    tick();
    avm_waitrequest = 1'b0;
    #1;
    chk("done_m1_wait", 32'(a_m1_wr), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("run_m1_write_%0d", k), 32'(a_write), 32'd1);
      chk($sformatf("run_m0_wait_%0d", k), 32'(a_m0_wr), 32'd1);
    end
    tick();
    chk("hand_m0_wait", 32'(a_m0_wr), 32'd0);
    chk("hand_write", 32'(a_write), 32'd0);
    chk("hand_read", 32'(a_read), 32'd1);

    // m0 abandons a stalled read with m1 idle
    m1_write = 1'b0; avm_waitrequest = 1'b1;
    tick();
    m0_read = 1'b0;
    #1;
    chk("abandon_read", 32'(a_read), 32'd0);
    tick();
    chk("ab_idle_read", 32'(a_read), 32'd0);
    chk("ab_idle_m0_wait", 32'(a_m0_wr), 32'd1);
    m1_read = 1'b1; m1_address = 5'd4; avm_waitrequest = 1'b0;
    #1;
    chk("ab_idle_m1_wait", 32'(a_m1_wr), 32'd1);
    tick();
    chk("g1_read", 32'(a_read), 32'd1);
    chk("g1_addr", 32'(a_addr), 32'd4);
    chk("g1_m1_wait", 32'(a_m1_wr), 32'd0);

    // Reset mid-stall in GRANT1, then tie goes to m0
    tick();
    avm_waitrequest = 1'b1; m0_read = 1'b1; m0_address = 5'd8;
    #1;
    chk("pre_rst_m1_wait", 32'(a_m1_wr), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_read", 32'(a_read), 32'd0);
    chk("mid_rst_addr", 32'(a_addr), 32'd0);
    chk("mid_rst_m0_wait", 32'(a_m0_wr), 32'd1);
    chk("mid_rst_m1_wait", 32'(a_m1_wr), 32'd1);
    chk("mid_rst_wdata", a_wdata, 32'd0);
    tick();
    rst = 1'b0; avm_waitrequest = 1'b0;
    #1;
    chk("post_rst_idle", 32'(a_read), 32'd0);
    tick();
    chk("post_rst_addr", 32'(a_addr), 32'd8);
    chk("post_rst_m0_wait", 32'(a_m0_wr), 32'd0);
    chk("post_rst_m1_wait", 32'(a_m1_wr), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
